// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Sweeps the select code {A,B,C} of an external 3-input decoder-based logic
// function through 0..7. Each code is held for SETTLE cycles, and then the
// returned output L is sampled into an 8-bit truth table. The finished table
// is offered on a valid/ready port.
//
// Optional feature macro: TTS_POPCNT_EN
//   When defined, tbl_ones (a registered population count of tbl) is present.
//
// Parameters:
//   SETTLE     : cycles each code is held before L is sampled (1..15)
//
// Ports:
//   clk        : clock, rising-edge active
//   rst        : asynchronous active-high reset
//   start      : scan request, only honoured in IDLE
//   A, B, C    : registered select code (A = MSB), zero outside SCAN
//   L          : function output returned for the current code
//   busy       : high while scanning or holding a finished table
//   tbl        : captured truth table, tbl[i] = L for code i
//   tbl_valid  : tbl is complete and stable
//   tbl_ready  : consumer accepts tbl
//   tbl_ones   : number of ones in tbl (TTS_POPCNT_EN only)
module truth_table_scanner #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       L,
  output logic       busy,
  output logic [7:0] tbl,
  output logic       tbl_valid,
  input  logic       tbl_ready
`ifdef TTS_POPCNT_EN
  ,
  output logic [3:0] tbl_ones
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_r;
  logic [2:0] code_r;
  logic [3:0] cnt_r;
  logic [2:0] abc_r;
  logic       busy_r;
  logic [7:0] tbl_r;
  logic       tbl_valid_r;
`ifdef TTS_POPCNT_EN
  logic [3:0] tbl_ones_r;
`endif

  logic       hold_done_s;
  logic       last_code_s;
  logic [2:0] code_next_s;

  // Sample strobe and next-code arithmetic for the scan sequencer.
  always_comb begin
    hold_done_s = (cnt_r == SETTLE_LAST);
    last_code_s = (code_r == 3'd7);
    code_next_s = code_r + 3'd1;
  end

  // Scan FSM with all outputs registered; start and tbl_ready are only
  // looked at in the state where they matter, so nothing is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      code_r      <= 3'd0;
      cnt_r       <= 4'd0;
      abc_r       <= 3'd0;
      busy_r      <= 1'b0;
      tbl_r       <= 8'h00;
      tbl_valid_r <= 1'b0;
`ifdef TTS_POPCNT_EN
      tbl_ones_r  <= 4'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_SCAN;
            code_r     <= 3'd0;
            cnt_r      <= 4'd0;
            abc_r      <= 3'd0;
            busy_r     <= 1'b1;
            tbl_r      <= 8'h00;
`ifdef TTS_POPCNT_EN
            tbl_ones_r <= 4'd0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SCAN: begin
          if (hold_done_s) begin
            tbl_r[code_r] <= L;
`ifdef TTS_POPCNT_EN
            tbl_ones_r    <= tbl_ones_r + {3'b000, L};
`endif
            cnt_r         <= 4'd0;
            code_r        <= code_next_s;
            if (last_code_s) begin
              // Code wraps to 0 and the select lines return to 0 with it.
              state_r     <= ST_DONE;
              abc_r       <= 3'd0;
              tbl_valid_r <= 1'b1;
            end else begin
              abc_r <= code_next_s;
            end
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end

        ST_DONE: begin
          if (tbl_ready) begin
            state_r     <= ST_IDLE;
            tbl_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          code_r      <= 3'd0;
          cnt_r       <= 4'd0;
          abc_r       <= 3'd0;
          busy_r      <= 1'b0;
          tbl_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign A         = abc_r[2];
  assign B         = abc_r[1];
  assign C         = abc_r[0];
  assign busy      = busy_r;
  assign tbl       = tbl_r;
  assign tbl_valid = tbl_valid_r;
`ifdef TTS_POPCNT_EN
  assign tbl_ones  = tbl_ones_r;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  logic clk;
  logic rst;

  // Instance with SETTLE=1 and the decoder function L = m1+m3+m6+m7.
  logic       start1, ready1, a1, b1, c1, busy1, valid1;
  logic [7:0] tbl1;
  logic [2:0] abc1;
  logic       l1;
  // Instance with SETTLE=3 and L driven directly by the bench.
  logic       start3, ready3, a3, b3, c3, busy3, valid3, l3;
  logic [7:0] tbl3;
  logic [2:0] abc3;
`ifdef TTS_POPCNT_EN
  logic [3:0] ones1, ones3;
`endif

  int total = 0;
  int bad   = 0;

  assign abc1 = {a1, b1, c1};
  assign abc3 = {a3, b3, c3};
  assign l1   = (abc1 == 3'd1) || (abc1 == 3'd3) || (abc1 == 3'd6) || (abc1 == 3'd7);

  truth_table_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .A(a1), .B(b1), .C(c1), .L(l1),
    .busy(busy1), .tbl(tbl1), .tbl_valid(valid1), .tbl_ready(ready1)
`ifdef TTS_POPCNT_EN
    , .tbl_ones(ones1)
`endif
  );

  truth_table_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .A(a3), .B(b3), .C(c3), .L(l3),
    .busy(busy3), .tbl(tbl3), .tbl_valid(valid3), .tbl_ready(ready3)
`ifdef TTS_POPCNT_EN
    , .tbl_ones(ones3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on dut1, follow the code sweep, stop on the first DONE cycle.
  task automatic scan1();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("s1_abc", 32'(abc1), 32'(k));
      chk("s1_busy", 32'(busy1), 32'd1);
      chk("s1_valid_lo", 32'(valid1), 32'd0);
      @(negedge clk);
    end
    chk("s1_valid", 32'(valid1), 32'd1);
    chk("s1_tbl", 32'(tbl1), 32'hCA);
    chk("s1_abc_done", 32'(abc1), 32'd0);
`ifdef TTS_POPCNT_EN
    chk("s1_ones", 32'(ones1), 32'd4);
`endif
  endtask

  // Pulse start on dut3, check each code is held for three cycles.
  task automatic scan3(input logic [7:0] exp_tbl, input logic [3:0] exp_ones);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk("s3_abc", 32'(abc3), 32'(k / 3));
      chk("s3_valid_lo", 32'(valid3), 32'd0);
      @(negedge clk);
    end
    chk("s3_valid", 32'(valid3), 32'd1);
    chk("s3_tbl", 32'(tbl3), 32'(exp_tbl));
    chk("s3_abc_done", 32'(abc3), 32'd0);
`ifdef TTS_POPCNT_EN
    chk("s3_ones", 32'(ones3), 32'(exp_ones));
`else
    if (exp_ones > 4'd8) chk("s3_ones_arg", 32'(exp_ones), 32'd8);
`endif
    @(negedge clk);
    chk("s3_valid_drop", 32'(valid3), 32'd0);
    chk("s3_busy_drop", 32'(busy3), 32'd0);
  endtask

  initial begin
    int rise_at[8];
    int nrise;
    logic prev_busy;

    rst = 1'b1;
    start1 = 1'b0; ready1 = 1'b1;
    start3 = 1'b0; ready3 = 1'b1; l3 = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_abc", 32'(abc1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_tbl", 32'(tbl1), 32'h00);
    chk("rst_valid", 32'(valid1), 32'd0);
`ifdef TTS_POPCNT_EN
    chk("rst_ones", 32'(ones1), 32'd0);
`endif
    rst = 1'b0;

    // Basic scan, valid lasts one cycle with ready high
    scan1();
    @(negedge clk);
    chk("hs_valid", 32'(valid1), 32'd0);
    chk("hs_busy", 32'(busy1), 32'd0);
    chk("idle_tbl_kept", 32'(tbl1), 32'hCA);

    // Back-pressure with start pulsed while in DONE
    ready1 = 1'b0;
    scan1();
    for (int i = 0; i < 10; i++) begin
      start1 = (i == 2) || (i == 3);
      @(negedge clk);
      chk("bp_valid", 32'(valid1), 32'd1);
      chk("bp_tbl", 32'(tbl1), 32'hCA);
      chk("bp_abc", 32'(abc1), 32'd0);
      chk("bp_busy", 32'(busy1), 32'd1);
    end
    start1 = 1'b1;
    ready1 = 1'b1;
    @(negedge clk);
    chk("bp_xfer_valid", 32'(valid1), 32'd0);
    chk("bp_xfer_busy", 32'(busy1), 32'd0);
    start1 = 1'b0;
    @(negedge clk);
    chk("bp_no_rescan", 32'(busy1), 32'd0);
    chk("bp_idle_abc", 32'(abc1), 32'd0);

    // Reset in the middle of a scan at code 4
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_abc", 32'(abc1), 32'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_abc", 32'(abc1), 32'd0);
    chk("mid_rst_tbl", 32'(tbl1), 32'h00);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_valid", 32'(valid1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    scan1();
    @(negedge clk);
    chk("post_rst_idle", 32'(busy1), 32'd0);

    // Start held high: back-to-back scans 10 cycles apart
    nrise = 0;
    prev_busy = busy1;
    start1 = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (busy1 && !prev_busy && nrise < 8) begin
        rise_at[nrise] = c;
        nrise++;
      end
      if (valid1) chk("b2b_tbl", 32'(tbl1), 32'hCA);
      prev_busy = busy1;
    end
    start1 = 1'b0;
    chk("b2b_count", 32'(nrise), 32'd4);
    if (nrise >= 3) begin
      chk("b2b_gap1", 32'(rise_at[1] - rise_at[0]), 32'd10);
      chk("b2b_gap2", 32'(rise_at[2] - rise_at[1]), 32'd10);
    end
    repeat (15) @(negedge clk);
    chk("b2b_drain", 32'(busy1), 32'd0);

    // SETTLE=3 with L tied high then low
    l3 = 1'b1;
    scan3(8'hFF, 4'd8);
    l3 = 1'b0;
    scan3(8'h00, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
